// File: rtl/stdp_pkg.sv
// Shared fixed-point constants and clamp/saturate helpers for the STDP synapse.
package stdp_pkg;

  // Fixed-point 1.0 for a given number of fraction bits.
  function automatic int unsigned fx_one(input int unsigned decimal_bits);
    return 32'd1 << decimal_bits;
  endfunction

  localparam int unsigned DECIMAL_BITS_DEFAULT = 7;
  localparam int unsigned ONE = fx_one(DECIMAL_BITS_DEFAULT);

  // Upper clamp; callers zero-extend into 64 bits so nothing can wrap.
  function automatic logic [63:0] sat_hi(input logic [63:0] v, input logic [63:0] hi);
    return (v > hi) ? hi : v;
  endfunction

  // Subtraction floored at zero.
  function automatic logic [63:0] sub_sat0(input logic [63:0] a, input logic [63:0] b);
    return (b > a) ? 64'd0 : a - b;
  endfunction

endpackage

// File: rtl/stdp_synapse_array_if.sv
// Host weight load/readback bus for the STDP synapse array.
interface stdp_synapse_array_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned AW = $clog2(N_CH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/stdp_ltp_scan.sv
// Sequential LTP scan: one shared multiplier walks the channels after a post-spike.
module stdp_ltp_scan
  import stdp_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DECIMAL_BITS = 7,
  parameter int unsigned A_PLUS_SHIFT = 5,
  parameter int unsigned W_MAX        = 2 * fx_one(DECIMAL_BITS),
  localparam int unsigned AW          = $clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        post_spike,
  input  logic                        learn_en,
  input  logic [N_CH-1:0][WIDTH-1:0]  pre_trace,
  input  logic [WIDTH-1:0]            cur_w,
  output logic                        wr_stb,
  output logic [AW-1:0]               wr_idx,
  output logic [WIDTH-1:0]            wr_val,
  output logic                        busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam int unsigned PSHIFT = DECIMAL_BITS + A_PLUS_SHIFT;
  localparam logic [AW-1:0] LAST = AW'(N_CH - 1);

  logic [0:0]                 state;
  logic [AW-1:0]              idx;
  logic                       pending;
  logic [N_CH-1:0][WIDTH-1:0] snap;
  logic [WIDTH-1:0]           headroom;
  logic [2*WIDTH-1:0]         prod;

  // Potentiation of the channel under the scan pointer, clamped at W_MAX.
  always_comb begin
    headroom = WIDTH'(sub_sat0(64'(W_MAX), 64'(cur_w)));
    prod     = (2*WIDTH)'(snap[idx]) * (2*WIDTH)'(headroom);
    wr_val   = WIDTH'(sat_hi(64'(cur_w) + 64'(prod >> PSHIFT), 64'(W_MAX)));
  end

  assign wr_stb = (state == SCAN) && learn_en;
  assign wr_idx = idx;
  assign busy   = (state == SCAN);

  // Scan FSM; a post-spike on the final step is folded into the pending rescan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      snap    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (post_spike && learn_en) begin
            snap    <= pre_trace;
            idx     <= '0;
            pending <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (!learn_en) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
          end else if (idx == LAST) begin
            idx     <= '0;
            pending <= 1'b0;
            if (pending || post_spike) snap  <= pre_trace;
            else                       state <= IDLE;
          end else begin
            idx <= idx + AW'(1);
            if (post_spike) pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stdp_synapse_array.sv
// Multi-input STDP synapse: per-channel traces, parallel LTD, scanned LTP, summed current.
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DECIMAL_BITS  = 7,
  parameter int unsigned TRACE_SHIFT   = 4,
  parameter int unsigned A_PLUS_SHIFT  = 5,
  parameter int unsigned A_MINUS_SHIFT = 6,
  parameter int unsigned W_MAX         = 2 * fx_one(DECIMAL_BITS),
  parameter int unsigned W_INIT        = fx_one(DECIMAL_BITS),
  parameter int unsigned ISYN_SHIFT    = 2,
  localparam int unsigned AW           = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CH-1:0]      pre_spike,
  input  logic                 post_spike,
  input  logic                 learn_en,
  stdp_synapse_array_if.slave  host,
  output logic [WIDTH+AW-1:0]  i_syn,
  output logic                 busy
);
  localparam int unsigned ONE_FX = fx_one(DECIMAL_BITS);
  localparam int unsigned MSHIFT = DECIMAL_BITS + A_MINUS_SHIFT;
  localparam logic [63:0] SAT    = (64'd1 << WIDTH) - 64'd1;

  logic [N_CH-1:0][WIDTH-1:0] weight, w_next;
  logic [N_CH-1:0][WIDTH-1:0] pre_trace, tr_next;
  logic [WIDTH-1:0]           post_trace, post_next;
  logic [WIDTH+AW-1:0]        isyn_next;
  logic                       scan_stb;
  logic [AW-1:0]              scan_idx;
  logic [WIDTH-1:0]           scan_val;

  stdp_ltp_scan #(
    .N_CH        (N_CH),
    .WIDTH       (WIDTH),
    .DECIMAL_BITS(DECIMAL_BITS),
    .A_PLUS_SHIFT(A_PLUS_SHIFT),
    .W_MAX       (W_MAX)
  ) u_scan (
    .clk       (clk),
    .reset_n   (reset_n),
    .post_spike(post_spike),
    .learn_en  (learn_en),
    .pre_trace (pre_trace),
    .cur_w     (weight[scan_idx]),
    .wr_stb    (scan_stb),
    .wr_idx    (scan_idx),
    .wr_val    (scan_val),
    .busy      (busy)
  );

  // Decaying traces with saturating spike increments.
  always_comb begin
    tr_next = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      tr_next[c] = WIDTH'(sat_hi(64'(pre_trace[c]) - 64'(pre_trace[c] >> TRACE_SHIFT)
                                 + (pre_spike[c] ? 64'(ONE_FX) : 64'd0), SAT));
    end
    post_next = WIDTH'(sat_hi(64'(post_trace) - 64'(post_trace >> TRACE_SHIFT)
                              + (post_spike ? 64'(ONE_FX) : 64'd0), SAT));
  end

  // Per-channel weight update: host write, then scan write, then LTD.
  always_comb begin
    w_next = weight;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (host.wr_en && host.wr_addr == AW'(c))
        w_next[c] = WIDTH'(sat_hi(64'(host.wr_data), 64'(W_MAX)));
      else if (scan_stb && scan_idx == AW'(c))
        w_next[c] = scan_val;
      else if (pre_spike[c] && learn_en)
        w_next[c] = WIDTH'(sub_sat0(64'(weight[c]),
                      64'(((2*WIDTH)'(post_trace) * (2*WIDTH)'(weight[c])) >> MSHIFT)));
    end
  end

  // Synaptic current from pre-update weights of spiking channels.
  always_comb begin
    isyn_next = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (pre_spike[c]) isyn_next = isyn_next + (WIDTH+AW)'(weight[c] >> ISYN_SHIFT);
    end
  end

  // State registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < N_CH; c++) weight[c] <= WIDTH'(W_INIT);
      pre_trace    <= '0;
      post_trace   <= '0;
      i_syn        <= '0;
      host.rd_data <= '0;
    end else begin
      weight       <= w_next;
      pre_trace    <= tr_next;
      post_trace   <= post_next;
      i_syn        <= isyn_next;
      host.rd_data <= weight[host.rd_addr];
    end
  end

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed bench for stdp_synapse_array with hand-computed expectations.
module tb_stdp_synapse_array;
  import stdp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  pre_spike = '0;
  logic        post_spike = 1'b0;
  logic        learn_en = 1'b0;
  logic [17:0] i_syn;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  stdp_synapse_array_if #(.N_CH(4), .WIDTH(16)) host ();

  stdp_synapse_array #(
    .N_CH(4), .WIDTH(16), .DECIMAL_BITS(7), .TRACE_SHIFT(4),
    .A_PLUS_SHIFT(5), .A_MINUS_SHIFT(6), .W_MAX(256), .W_INIT(128), .ISYN_SHIFT(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pre_spike (pre_spike),
    .post_spike(post_spike),
    .learn_en  (learn_en),
    .host      (host),
    .i_syn     (i_syn),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    pre_spike    = '0;
    post_spike   = 1'b0;
    learn_en     = 1'b0;
    host.wr_en   = 1'b0;
    host.wr_addr = '0;
    host.wr_data = '0;
    host.rd_addr = '0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic read_w(input int ch, input int exp, input string tag);
    host.rd_addr = 2'(ch);
    step();
    check_val(tag, 32'(host.rd_data), exp);
  endtask

  task automatic host_write(input int ch, input int val);
    host.wr_en   = 1'b1;
    host.wr_addr = 2'(ch);
    host.wr_data = 16'(val);
    step();
    host.wr_en   = 1'b0;
  endtask

  // Post-spike at i=0; optional second post, learn_en drop, pre pattern and ch0 host write.
  task automatic run_scan(input int second, input int drop, input int pre_at,
                          input logic [3:0] pat, input int wr_at, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      post_spike   = (i == 0) || (i == second);
      learn_en     = !(drop >= 0 && i >= drop);
      pre_spike    = (i == pre_at) ? pat : 4'b0000;
      host.wr_en   = (i == wr_at);
      host.wr_addr = 2'd0;
      host.wr_data = 16'd50;
      step();
      if (busy) n++;
      else if (i > 0) break;
    end
    post_spike = 1'b0;
    pre_spike  = '0;
    host.wr_en = 1'b0;
    learn_en   = 1'b1;
  endtask

  initial begin
    int n;

    // Reset state
    do_reset();
    reset_n = 1'b0;
    #1;
    check_val("rst_rd_data", 32'(host.rd_data), 0);
    check_val("rst_i_syn", 32'(i_syn), 0);
    check_val("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) read_w(c, ONE, $sformatf("rst_w%0d", c));

    // Single pre-spike: current and trace decay
    pre_spike = 4'b0001;
    step();
    pre_spike = '0;
    check_val("isyn_ch0", 32'(i_syn), 32);
    check_val("trace0_t0", 32'(dut.pre_trace[0]), 128);
    step();
    check_val("trace0_t1", 32'(dut.pre_trace[0]), 120);
    check_val("isyn_idle", 32'(i_syn), 0);
    step();
    check_val("trace0_t2", 32'(dut.pre_trace[0]), 113);
    pre_spike = 4'b1111;
    step();
    pre_spike = '0;
    check_val("isyn_all", 32'(i_syn), 128);

    // LTP: pre ch0 then post
    do_reset();
    learn_en  = 1'b1;
    pre_spike = 4'b0001;
    step();
    run_scan(-1, -1, -1, 4'b0000, -1, n);
    check_val("ltp_busy_cycles", n, 4);
    read_w(0, 132, "ltp_w0");
    for (int c = 1; c < 4; c++) read_w(c, 128, $sformatf("ltp_w%0d", c));

    // LTD: post then pre ch1, alongside the scan
    do_reset();
    run_scan(-1, -1, 1, 4'b0010, -1, n);
    check_val("ltd_busy_cycles", n, 4);
    read_w(1, 126, "ltd_w1");
    read_w(0, 128, "ltd_w0");

    // Host write clamping and current
    do_reset();
    host_write(2, 300);
    read_w(2, 256, "wr_clamp_hi");
    pre_spike = 4'b0110;
    step();
    pre_spike = '0;
    check_val("isyn_0110", 32'(i_syn), 96);
    host_write(2, 0);
    read_w(2, 0, "wr_zero");
    pre_spike = 4'b0100;
    step();
    pre_spike = '0;
    check_val("isyn_zero_w", 32'(i_syn), 0);

    // Rescan from a second post-spike mid-scan
    do_reset();
    learn_en  = 1'b1;
    pre_spike = 4'b1111;
    step();
    run_scan(2, -1, -1, 4'b0000, -1, n);
    check_val("rescan_busy_cycles", n, 8);
    for (int c = 0; c < 4; c++) read_w(c, 135, $sformatf("rescan_w%0d", c));

    // learn_en drop aborts the scan
    do_reset();
    learn_en  = 1'b1;
    pre_spike = 4'b1111;
    step();
    run_scan(-1, 2, -1, 4'b0000, -1, n);
    check_val("abort_busy_cycles", n, 2);
    read_w(0, 132, "abort_w0");
    read_w(1, 128, "abort_w1");
    read_w(3, 128, "abort_w3");

    // Host write wins over the scan write to the same channel
    do_reset();
    learn_en  = 1'b1;
    pre_spike = 4'b1111;
    step();
    run_scan(-1, -1, -1, 4'b0000, 1, n);
    check_val("prio_busy_cycles", n, 4);
    read_w(0, 50, "prio_w0");
    read_w(1, 132, "prio_w1");

    // Asynchronous reset mid-scan
    do_reset();
    learn_en   = 1'b1;
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    step();
    check_val("midscan_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midscan_rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_val("post_rst_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
